laser_point_loader: RTL and testbench
=====================================

// Module: laser_point_loader
// PURPOSE
//  Front-end stage of the LASER circle-cover engine. Captures NUM_PTS target points (X,Y), one per cycle,
//  into an internal point table and bins each point into one of four quadrants while it is captured.
//  After capture it ranks the quadrants (largest, second largest). It then holds the table on two
//  asynchronous read ports. The downstream circle-search block uses the ranking for its two search origins.
// PARAMETERS
//  NUM_PTS   40  points captured per frame
//  COORD_W    4  bits per coordinate; quadrant split at 2**(COORD_W-1)
//  CNT_W      6  quadrant-counter width; must satisfy 2**CNT_W > NUM_PTS
// PORTS
//  CLK       in   1        clock, rising edge
//  RST       in   1        asynchronous, active-high reset
//  start     in   1        arm a capture; honoured only in IDLE
//  X         in   COORD_W  point x, sampled during LOAD
//  Y         in   COORD_W  point y, sampled during LOAD
//  release   in   1        consumer finished; READY -> IDLE
//  busy      out  1        1 in LOAD or RANK
//  ready     out  1        1 in READY; table and ranking valid
//  max_q     out  2        quadrant with most points (0=LU,1=RU,2=LD,3=RD)
//  sec_q     out  2        quadrant with second-most points; always != max_q
//  cnt_lu, cnt_ru, cnt_ld, cnt_rd   out  CNT_W  per-quadrant point counts
//  rd_idx_a  in   6        read-port A index
//  rd_idx_b  in   6        read-port B index
//  rd_x_a, rd_y_a, rd_x_b, rd_y_b   out  COORD_W  table data at rd_idx_*; combinational read
// BEHAVIOUR
//  Reset: state IDLE; busy=0, ready=0, max_q=0, sec_q=1, all cnt_*=0, load index=0.
//   Table contents are not reset. rd_* outputs are don't-care until ready=1.
//  FSM: IDLE -> LOAD -> RANK -> READY -> IDLE.
//   IDLE : start=1 at edge t0 -> LOAD. cnt_* are cleared and ranking regs are re-initialised on the same edge.
//   LOAD : on each edge t0+1 .. t0+NUM_PTS, store (X,Y) at table[idx], increment idx, and increment
//          exactly one quadrant counter. The edge that stores idx=NUM_PTS-1 -> RANK, idx <- 0.
//   RANK : 4 cycles, step k=0..3 over counts c[k] (LU,RU,LD,RD), on edges t0+NUM_PTS+1 .. +4.
//          k=0: max_q<=0, max_v<=c0, sec_q<=1, sec_v<=0.
//          k>0: if c[k] > max_v then sec<=max, sec_v<=max_v, max<=k, max_v<=c[k];
//               else if c[k] > sec_v then sec<=k, sec_v<=c[k].
//          Strict compares, so on a tie the lower quadrant index wins. Step 3 -> READY.
//   READY: ready=1 from edge t0+NUM_PTS+4 (44 cycles after start for NUM_PTS=40).
//          All outputs are held stable. release=1 -> IDLE on the next edge.
//  Quadrant rule: x<8 and y<8 -> LU; x>=8 and y<8 -> RU; x<8 and y>=8 -> LD; x>=8 and y>=8 -> RD.
//   Each point lands in exactly one quadrant, so sum of cnt_* == NUM_PTS in READY.
//  Read ports: rd_idx >= NUM_PTS returns 0. The two ports are independent; same index on both is legal.
//  Boundaries:
//   start outside IDLE is ignored. start and release together in READY: release wins; start is dropped.
//   X/Y outside LOAD are ignored.
//   RST in any state, including mid-LOAD: immediate return to IDLE, counters cleared, partial frame discarded.
//   A new frame overwrites the table in place. No stale entries survive a completed frame.
// STRUCTURE
//  Shared package laser_pkg: quadrant enum (Q_LU=0, Q_RU=1, Q_LD=2, Q_RD=3), NUM_PTS, COORD_W,
//   CNT_W, HALF=2**(COORD_W-1). The downstream circle-search block uses the same package.
//  One sub-module: laser_quad_rank. It holds the 4-step sequential max/second tracker, with
//   inputs c[0..3] and step, and outputs max_q and sec_q.
//  Table is a register array NUM_PTS x 2*COORD_W with one write port and two read ports.
// TESTING
//  1 Assert RST, then release it -> busy=0, ready=0, max_q=0, sec_q=1, all cnt_*=0.
//  2 start, then 40 points all at (3,3) -> ready rises 44 cycles after start; cnt_lu=40, others 0;
//    max_q=0, sec_q=1; rd_idx_a=39 returns (3,3).
//  3 10 LU, 15 RU, 5 LD, 10 RD -> max_q=1; sec_q=0 (LU/RD tie, lower index wins).
//    Point i read back exactly via both ports.
//  4 Points (7,7), (8,7), (7,8), (8,8), then 36 at (15,15) -> cnt 1/1/1/37; max_q=3, sec_q=0.
//  5 RST pulse after 20 points of LOAD -> IDLE, cnt_*=0, busy=0.
//    A fresh start with 40 points then completes correctly.
//  6 In READY: start alone is ignored; start+release -> IDLE with no capture.
//    start during LOAD is ignored (idx is not reset).
//    A second frame of different points overwrites all 40 entries.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared definitions for the LASER circle-cover engine: geometry parameters,
// quadrant encoding and the point-loader FSM states.
package laser_pkg;

    localparam int NUM_PTS = 40;
    localparam int COORD_W = 4;
    localparam int CNT_W   = 6;
    localparam int IDX_W   = 6;
    localparam int HALF    = 2 ** (COORD_W - 1);

    typedef enum logic [1:0] {
        Q_LU = 2'd0,
        Q_RU = 2'd1,
        Q_LD = 2'd2,
        Q_RD = 2'd3
    } quad_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RANK  = 2'd2,
        S_READY = 2'd3
    } state_t;

    // The split at HALF is exactly the coordinate MSB; bit 0 of the code is
    // "right half", bit 1 is "lower half".
    function automatic quad_t quad_of(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        return quad_t'({y[COORD_W-1], x[COORD_W-1]});
    endfunction

endpackage

// File: rtl/laser_point_loader_if.sv
// Bus between the point loader and its producer/consumer.
// Handshake: start is an IDLE-only request; busy/ready report the FSM phase;
// release_frame in READY hands the frame back and returns the loader to IDLE
// on the next edge (it overrides a simultaneous start). dbg_state mirrors the FSM.
interface laser_point_loader_if import laser_pkg::*; ();

    logic                 start;
    logic [COORD_W-1:0]   X;
    logic [COORD_W-1:0]   Y;
    logic                 release_frame;
    logic                 busy;
    logic                 ready;
    quad_t                max_q;
    quad_t                sec_q;
    logic [CNT_W-1:0]     cnt_lu;
    logic [CNT_W-1:0]     cnt_ru;
    logic [CNT_W-1:0]     cnt_ld;
    logic [CNT_W-1:0]     cnt_rd;
    logic [IDX_W-1:0]     rd_idx_a;
    logic [IDX_W-1:0]     rd_idx_b;
    logic [COORD_W-1:0]   rd_x_a;
    logic [COORD_W-1:0]   rd_y_a;
    logic [COORD_W-1:0]   rd_x_b;
    logic [COORD_W-1:0]   rd_y_b;
    state_t               dbg_state;

    modport master (
        output start, X, Y, release_frame, rd_idx_a, rd_idx_b,
        input  busy, ready, max_q, sec_q, cnt_lu, cnt_ru, cnt_ld, cnt_rd,
        input  rd_x_a, rd_y_a, rd_x_b, rd_y_b, dbg_state
    );

    modport slave (
        input  start, X, Y, release_frame, rd_idx_a, rd_idx_b,
        output busy, ready, max_q, sec_q, cnt_lu, cnt_ru, cnt_ld, cnt_rd,
        output rd_x_a, rd_y_a, rd_x_b, rd_y_b, dbg_state
    );

endinterface

// File: rtl/laser_quad_rank.sv
// Sequential largest / second-largest tracker over four quadrant counts,
// one count per step. Strict compares make the lower quadrant win a tie.
module laser_quad_rank import laser_pkg::*; (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      init,
    input  logic                      step_en,
    input  logic [1:0]                step,
    input  logic [3:0][CNT_W-1:0]     c,
    output quad_t                     max_q,
    output quad_t                     sec_q
);

    logic [CNT_W-1:0] max_v;
    logic [CNT_W-1:0] sec_v;
    logic [CNT_W-1:0] ck;

    assign ck = c[step];

    // Step 0 seeds the tracker with LU; later steps displace max or second.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            max_q <= Q_LU;
            sec_q <= Q_RU;
            max_v <= '0;
            sec_v <= '0;
        end else if (init) begin
            max_q <= Q_LU;
            sec_q <= Q_RU;
            max_v <= '0;
            sec_v <= '0;
        end else if (step_en) begin
            if (step == 2'd0) begin
                max_q <= Q_LU;
                max_v <= c[0];
                sec_q <= Q_RU;
                sec_v <= '0;
            end else if (ck > max_v) begin
                sec_q <= max_q;
                sec_v <= max_v;
                max_q <= quad_t'(step);
                max_v <= ck;
            end else if (ck > sec_v) begin
                sec_q <= quad_t'(step);
                sec_v <= ck;
            end
        end
    end

endmodule

// File: rtl/laser_point_loader.sv
// Captures one frame of NUM_PTS points, bins them into quadrants on the fly,
// ranks the quadrants and then serves the point table on two read ports.
module laser_point_loader import laser_pkg::*; (
    input  logic                  CLK,
    input  logic                  RST,
    laser_point_loader_if.slave   bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_PTS);

    state_t                   state;
    state_t                   state_nx;
    logic [IDX_W-1:0]         idx;
    logic [1:0]               rank_k;
    logic [3:0][CNT_W-1:0]    cnt;
    logic [2*COORD_W-1:0]     table_q [NUM_PTS];
    logic                     arm;
    logic                     capture;
    logic [1:0]               q_in;
    logic [2*COORD_W-1:0]     rd_a;
    logic [2*COORD_W-1:0]     rd_b;
    quad_t                    max_q;
    quad_t                    sec_q;

    assign arm     = (state == S_IDLE) && bus.start;
    assign capture = (state == S_LOAD);
    assign q_in    = quad_of(bus.X, bus.Y);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: release in READY takes priority over any start.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start)             state_nx = S_LOAD;
            S_LOAD:  if (idx == LAST_IDX)       state_nx = S_RANK;
            S_RANK:  if (rank_k == 2'd3)        state_nx = S_READY;
            S_READY: if (bus.release_frame)     state_nx = S_IDLE;
            default:                            state_nx = S_IDLE;
        endcase
    end

    // Phase outputs decoded from the current state.
    always_comb begin
        bus.busy  = 1'b0;
        bus.ready = 1'b0;
        case (state)
            S_LOAD, S_RANK: bus.busy  = 1'b1;
            S_READY:        bus.ready = 1'b1;
            default:        ;
        endcase
    end

    // Load index and ranking step; both wrap to zero when their phase ends.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx    <= '0;
            rank_k <= '0;
        end else if (arm) begin
            idx    <= '0;
            rank_k <= '0;
        end else if (capture) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else if (state == S_RANK) begin
            rank_k <= rank_k + 1'b1;
        end
    end

    // Quadrant counters: cleared when a frame is armed, one bump per captured point.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (arm) begin
            cnt <= '0;
        end else if (capture) begin
            cnt[q_in] <= cnt[q_in] + 1'b1;
        end
    end

    // Point table write port; contents survive reset and are overwritten per frame.
    always_ff @(posedge CLK) begin
        if (capture) table_q[idx] <= {bus.X, bus.Y};
    end

    // Two independent combinational read ports; out-of-range indices read zero.
    always_comb begin
        rd_a = (bus.rd_idx_a < NUM_IDX) ? table_q[bus.rd_idx_a] : '0;
        rd_b = (bus.rd_idx_b < NUM_IDX) ? table_q[bus.rd_idx_b] : '0;
    end

    laser_quad_rank u_rank (
        .CLK     (CLK),
        .RST     (RST),
        .init    (arm),
        .step_en (state == S_RANK),
        .step    (rank_k),
        .c       (cnt),
        .max_q   (max_q),
        .sec_q   (sec_q)
    );

    assign bus.max_q     = max_q;
    assign bus.sec_q     = sec_q;
    assign bus.cnt_lu    = cnt[0];
    assign bus.cnt_ru    = cnt[1];
    assign bus.cnt_ld    = cnt[2];
    assign bus.cnt_rd    = cnt[3];
    assign bus.rd_x_a    = rd_a[2*COORD_W-1:COORD_W];
    assign bus.rd_y_a    = rd_a[COORD_W-1:0];
    assign bus.rd_x_b    = rd_b[2*COORD_W-1:COORD_W];
    assign bus.rd_y_b    = rd_b[COORD_W-1:0];
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_laser_point_loader.sv
// Bench for laser_point_loader: frame-level reference model of quadrant counts,
// ranking and point table, driven with directed and random frames.
module tb_laser_point_loader;
    import laser_pkg::*;

    logic clk = 1'b0;
    logic rst;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    laser_point_loader_if bus ();

    laser_point_loader dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [COORD_W-1:0]   px [NUM_PTS];
    logic [COORD_W-1:0]   py [NUM_PTS];
    logic [2*COORD_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start         = 1'b0;
        bus.X             = '0;
        bus.Y             = '0;
        bus.release_frame = 1'b0;
        bus.rd_idx_a      = '0;
        bus.rd_idx_b      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic int model_quad(input int x, input int y);
        return ((x >= HALF) ? 1 : 0) + ((y >= HALF) ? 2 : 0);
    endfunction

    function automatic logic [COORD_W-1:0] coord_in(input int upper);
        return upper ? COORD_W'($urandom_range(2*HALF-1, HALF)) : COORD_W'($urandom_range(HALF-1, 0));
    endfunction

    // kind 0: all (3,3); 1: 10/15/5/10 shuffled; 2: boundary points; else random.
    task automatic gen_frame(input int kind);
        int qs [NUM_PTS];
        int j, t;
        for (int i = 0; i < NUM_PTS; i++) begin
            case (kind)
                0: begin px[i] = 4'd3; py[i] = 4'd3; end
                2: begin
                    if (i < 4) begin
                        px[i] = (i % 2 == 1) ? 4'd8 : 4'd7;
                        py[i] = (i >= 2)     ? 4'd8 : 4'd7;
                    end else begin
                        px[i] = 4'd15; py[i] = 4'd15;
                    end
                end
                default: begin
                    px[i] = COORD_W'($urandom_range(2*HALF-1, 0));
                    py[i] = COORD_W'($urandom_range(2*HALF-1, 0));
                end
            endcase
        end
        if (kind == 1) begin
            for (int i = 0; i < NUM_PTS; i++)
                qs[i] = (i < 10) ? 0 : (i < 25) ? 1 : (i < 30) ? 2 : 3;
            for (int i = NUM_PTS - 1; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = qs[i]; qs[i] = qs[j]; qs[j] = t;
            end
            for (int i = 0; i < NUM_PTS; i++) begin
                px[i] = coord_in(qs[i] % 2);
                py[i] = coord_in(qs[i] / 2);
            end
        end
    endtask

    // Frame-level expectation: counts by quadrant, then argmax and runner-up
    // with the lower quadrant index winning every tie.
    task automatic check_counts_rank(input string tag);
        int c [4];
        int mx, sc;
        for (int k = 0; k < 4; k++) c[k] = 0;
        for (int i = 0; i < NUM_PTS; i++) c[model_quad(px[i], py[i])]++;
        mx = 0;
        for (int k = 1; k < 4; k++) if (c[k] > c[mx]) mx = k;
        sc = -1;
        for (int k = 0; k < 4; k++)
            if (k != mx && (sc < 0 || c[k] > c[sc])) sc = k;
        check({tag, "_cnt_lu"}, 32'(bus.cnt_lu), c[0]);
        check({tag, "_cnt_ru"}, 32'(bus.cnt_ru), c[1]);
        check({tag, "_cnt_ld"}, 32'(bus.cnt_ld), c[2]);
        check({tag, "_cnt_rd"}, 32'(bus.cnt_rd), c[3]);
        check({tag, "_cnt_sum"}, 32'(bus.cnt_lu) + 32'(bus.cnt_ru) + 32'(bus.cnt_ld) + 32'(bus.cnt_rd), NUM_PTS);
        check({tag, "_max_q"}, 32'(bus.max_q), mx);
        check({tag, "_sec_q"}, 32'(bus.sec_q), sc);
    endtask

    // Drive one full frame; optional start pulse mid-LOAD must be ignored.
    task automatic run_frame(input string tag, input bit start_mid);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.X = COORD_W'($urandom); bus.Y = COORD_W'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        check({tag, "_busy_load"}, 32'(bus.busy), 1);
        for (int i = 0; i < NUM_PTS; i++) begin
            bus.X = px[i];
            bus.Y = py[i];
            bus.start = (start_mid && i == 10);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        while (!bus.ready && cyc < 200) begin
            check({tag, "_busy_rank"}, 32'(bus.busy), 1);
            bus.X = COORD_W'($urandom); bus.Y = COORD_W'($urandom);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready_latency"}, cyc, NUM_PTS + 4);
        check({tag, "_busy_ready"}, 32'(bus.busy), 0);
        check({tag, "_state_ready"}, 32'(bus.dbg_state), 32'(S_READY));
    endtask

    // Read every entry through both ports, plus out-of-range indices.
    task automatic readback(input string tag);
        logic [2*COORD_W-1:0] e;
        for (int i = 0; i < NUM_PTS; i++) exp_q.push_back({px[i], py[i]});
        for (int i = 0; i < NUM_PTS; i++) begin
            bus.rd_idx_a = IDX_W'(i);
            bus.rd_idx_b = IDX_W'(NUM_PTS - 1 - i);
            #1;
            e = exp_q.pop_front();
            check({tag, "_rd_a"}, 32'({bus.rd_x_a, bus.rd_y_a}), 32'(e));
            check({tag, "_rd_b"}, 32'({bus.rd_x_b, bus.rd_y_b}),
                  32'({px[NUM_PTS-1-i], py[NUM_PTS-1-i]}));
        end
        bus.rd_idx_a = IDX_W'(NUM_PTS);
        bus.rd_idx_b = IDX_W'($urandom_range(63, NUM_PTS));
        #1;
        check({tag, "_rd_a_oor"}, 32'({bus.rd_x_a, bus.rd_y_a}), 0);
        check({tag, "_rd_b_oor"}, 32'({bus.rd_x_b, bus.rd_y_b}), 0);
        bus.rd_idx_a = IDX_W'(NUM_PTS - 1);
        bus.rd_idx_b = IDX_W'(NUM_PTS - 1);
        #1;
        check({tag, "_rd_same_a"}, 32'({bus.rd_x_a, bus.rd_y_a}), 32'({px[NUM_PTS-1], py[NUM_PTS-1]}));
        check({tag, "_rd_same_b"}, 32'({bus.rd_x_b, bus.rd_y_b}), 32'({px[NUM_PTS-1], py[NUM_PTS-1]}));
    endtask

    task automatic release_ready(input string tag);
        @(negedge clk);
        bus.release_frame = 1'b1;
        @(negedge clk);
        bus.release_frame = 1'b0;
        check({tag, "_rel_ready"}, 32'(bus.ready), 0);
        check({tag, "_rel_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic full_frame(input string tag, input int kind, input bit start_mid);
        gen_frame(kind);
        run_frame(tag, start_mid);
        check_counts_rank(tag);
        readback(tag);
    endtask

    // Main sequence.
    initial begin
        do_reset();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ready", 32'(bus.ready), 0);
        check("rst_max_q", 32'(bus.max_q), 0);
        check("rst_sec_q", 32'(bus.sec_q), 1);
        check("rst_cnt_lu", 32'(bus.cnt_lu), 0);
        check("rst_cnt_ru", 32'(bus.cnt_ru), 0);
        check("rst_cnt_ld", 32'(bus.cnt_ld), 0);
        check("rst_cnt_rd", 32'(bus.cnt_rd), 0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));

        full_frame("all33", 0, 1'b0);
        release_ready("all33");
        full_frame("mix", 1, 1'b0);
        release_ready("mix");
        full_frame("edge", 2, 1'b0);
        release_ready("edge");

        // Reset in the middle of LOAD discards the partial frame.
        gen_frame(3);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.X = px[i]; bus.Y = py[i];
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_ready", 32'(bus.ready), 0);
        check("midrst_cnt", 32'(bus.cnt_lu) + 32'(bus.cnt_ru) + 32'(bus.cnt_ld) + 32'(bus.cnt_rd), 0);
        check("midrst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        full_frame("after_rst", 3, 1'b0);

        // READY: lone start is ignored, start+release returns to IDLE without capture.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("rdy_start_ready", 32'(bus.ready), 1);
        check("rdy_start_busy", 32'(bus.busy), 0);
        check_counts_rank("rdy_start");
        bus.start = 1'b1;
        bus.release_frame = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.release_frame = 1'b0;
        check("both_ready", 32'(bus.ready), 0);
        check("both_busy", 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("both_state", 32'(bus.dbg_state), 32'(S_IDLE));

        // start pulsed during LOAD, then further random frames overwriting the table.
        full_frame("start_mid", 3, 1'b1);
        release_ready("start_mid");
        for (int f = 0; f < 3; f++) begin
            full_frame($sformatf("rand%0d", f), 3, ($urandom_range(1, 0) == 1));
            release_ready($sformatf("rand%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
